vga_line_fetch_addr_gen: RTL and testbench

//  Per-scanline SDRAM read-address sequencer for the VGA framebuffer path. On each line_start it

---
 rtl/vga_mem_pkg.sv | 32 +++
 rtl/vga_line_fetch_addr_gen_if.sv | 24 ++
 rtl/vga_row_wrap.sv | 22 ++
 rtl/vga_line_fetch_addr_gen.sv | 155 +++++++++++++++
 tb/tb_vga_line_fetch_addr_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_mem_pkg.sv
// Shared SDRAM address geometry and fetch FSM types for the VGA framebuffer path.
package vga_mem_pkg;

  localparam int SDRAM_ROW_WIDTH   = 13;
  localparam int SDRAM_COL_WIDTH   = 9;
  localparam int SDRAM_BANK_WIDTH  = 2;
  localparam int SDRAM_HADDR_WIDTH = SDRAM_BANK_WIDTH + SDRAM_ROW_WIDTH + SDRAM_COL_WIDTH;

  typedef enum logic {
    IDLE,
    ISSUE
  } fetch_state_e;

  typedef struct packed {
    logic [SDRAM_BANK_WIDTH-1:0] bank;
    logic [SDRAM_ROW_WIDTH-1:0]  row;
    logic [SDRAM_COL_WIDTH-1:0]  col;
  } sdram_addr_t;

  function automatic logic [SDRAM_HADDR_WIDTH-1:0] pack_addr(
    input logic [SDRAM_BANK_WIDTH-1:0] bank,
    input logic [SDRAM_ROW_WIDTH-1:0]  row,
    input logic [SDRAM_COL_WIDTH-1:0]  col
  );
    return {bank, row, col};
  endfunction

  function automatic sdram_addr_t unpack_addr(input logic [SDRAM_HADDR_WIDTH-1:0] addr);
    return sdram_addr_t'(addr);
  endfunction

endpackage

// File: rtl/vga_line_fetch_addr_gen_if.sv
// Read-request port between the line fetch sequencer and the SDRAM controller.
interface vga_line_fetch_addr_gen_if
  import vga_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = SDRAM_HADDR_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready
  );

endinterface

// File: rtl/vga_row_wrap.sv
// Combinational framebuffer row wrap: (line + offset) mod FB_LINES, each input already < FB_LINES.
module vga_row_wrap #(
  parameter int LINE_WIDTH = 10,
  parameter int ROW_WIDTH  = 13,
  parameter int FB_LINES   = 512
) (
  input  logic [LINE_WIDTH-1:0] i_line,
  input  logic [LINE_WIDTH-1:0] i_offset,
  output logic [ROW_WIDTH-1:0]  o_row
);

  localparam logic [ROW_WIDTH:0] FB_LINES_EXT = (ROW_WIDTH + 1)'(FB_LINES);

  logic [ROW_WIDTH:0] w_sum;
  logic [ROW_WIDTH:0] w_wrapped;

  // One extra bit so the sum cannot overflow before the single conditional subtract
  assign w_sum     = (ROW_WIDTH + 1)'(i_line) + (ROW_WIDTH + 1)'(i_offset);
  assign w_wrapped = (w_sum >= FB_LINES_EXT) ? (w_sum - FB_LINES_EXT) : w_sum;
  assign o_row     = w_wrapped[ROW_WIDTH-1:0];

endmodule

// File: rtl/vga_line_fetch_addr_gen.sv
// Per-scanline SDRAM read-address sequencer: one burst train per line_start, with
// vertical scroll, framebuffer wrap and frame-synchronous double-buffer bank swap.
module vga_line_fetch_addr_gen
  import vga_mem_pkg::*;
#(
  parameter int ROW_WIDTH      = SDRAM_ROW_WIDTH,
  parameter int COL_WIDTH      = SDRAM_COL_WIDTH,
  parameter int BANK_WIDTH     = SDRAM_BANK_WIDTH,
  parameter int LINE_WIDTH     = 10,
  parameter int WORDS_PER_LINE = 320,
  parameter int BURST_LEN      = 8,
  parameter int FB_LINES       = 512,
  parameter int BANK_A         = 1,
  parameter int BANK_B         = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_frame_start,
  input  logic                             i_line_start,
  input  logic [LINE_WIDTH-1:0]            i_line_idx,
  input  logic [LINE_WIDTH-1:0]            i_scroll_offset,
  input  logic                             i_swap_req,
  vga_line_fetch_addr_gen_if.master        rd_if,
  output logic                             o_busy,
  output logic                             o_front_buf,
  output logic                             o_swap_done,
  output logic                             o_overrun
);

  localparam int                   HADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
  localparam logic [COL_WIDTH-1:0] LAST_COL    = COL_WIDTH'(WORDS_PER_LINE - BURST_LEN);
  localparam logic [COL_WIDTH-1:0] COL_STEP    = COL_WIDTH'(BURST_LEN);

  generate
    if ((WORDS_PER_LINE % BURST_LEN) != 0) begin : g_bad_burst
      $error("WORDS_PER_LINE must be a multiple of BURST_LEN");
    end
    if (FB_LINES > (2 ** ROW_WIDTH)) begin : g_bad_fb
      $error("FB_LINES must fit in ROW_WIDTH row bits");
    end
  endgenerate

  fetch_state_e            r_state;
  fetch_state_e            w_next_state;
  logic                    w_start;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_swap_now;
  logic                    w_front_eff;
  logic [LINE_WIDTH-1:0]   w_scroll_eff;
  logic [ROW_WIDTH-1:0]    w_row;
  logic [LINE_WIDTH-1:0]   r_scroll;
  logic                    r_front;
  logic                    r_swap_pend;
  logic                    r_swap_done;
  logic                    r_overrun;
  logic [BANK_WIDTH-1:0]   r_bank;
  logic [ROW_WIDTH-1:0]    r_row;
  logic [COL_WIDTH-1:0]    r_col;

  // A line started in the same cycle as frame_start must see that frame's scroll and buffer
  assign w_swap_now   = i_frame_start && (r_swap_pend || i_swap_req);
  assign w_front_eff  = w_swap_now ? ~r_front : r_front;
  assign w_scroll_eff = i_frame_start ? i_scroll_offset : r_scroll;

  vga_row_wrap #(
    .LINE_WIDTH (LINE_WIDTH),
    .ROW_WIDTH  (ROW_WIDTH),
    .FB_LINES   (FB_LINES)
  ) u_row_wrap (
    .i_line   (i_line_idx),
    .i_offset (w_scroll_eff),
    .o_row    (w_row)
  );

  assign rd_if.req_valid = (r_state == ISSUE);
  assign rd_if.req_addr  = HADDR_WIDTH'({r_bank, r_row, r_col});
  assign w_accept        = rd_if.req_valid && rd_if.req_ready;
  assign w_last          = (r_col == LAST_COL);

  assign o_busy      = (r_state == ISSUE);
  assign o_front_buf = r_front;
  assign o_swap_done = r_swap_done;
  assign o_overrun   = r_overrun;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_line_start) begin
          w_next_state = ISSUE;
          w_start      = 1'b1;
        end
      end
      ISSUE: begin
        if (w_accept && w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Line address capture and per-burst column stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_start) begin
      r_bank <= w_front_eff ? BANK_WIDTH'(BANK_B) : BANK_WIDTH'(BANK_A);
      r_row  <= w_row;
      r_col  <= '0;
    end else if (w_accept && !w_last) begin
      r_col  <= r_col + COL_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scroll    <= '0;
      r_front     <= 1'b0;
      r_swap_pend <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= w_swap_now;
      if (i_frame_start) begin
        r_scroll    <= i_scroll_offset;
        r_front     <= w_front_eff;
        r_swap_pend <= 1'b0;
      end else if (i_swap_req) begin
        r_swap_pend <= 1'b1;
      end
    end
  end

  // Includes the cycle the last burst is accepted: no back-to-back chaining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (i_line_start && (r_state == ISSUE)) begin
      r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch_addr_gen.sv
// Scoreboard bench: stimulus pushes expected addresses, a negedge monitor pops and compares.
module tb_vga_line_fetch_addr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frameStart = 1'b0;
  logic       lineStart = 1'b0;
  logic [9:0] lineIdx = '0;
  logic [9:0] scrollOffset = '0;
  logic       swapReq = 1'b0;
  logic       busy;
  logic       frontBuf;
  logic       swapDone;
  logic       overrun;
  int         readyMode = 0;
  int         testsRun = 0;
  int         testsFailed = 0;
  logic [23:0] sbQ[$];

  vga_line_fetch_addr_gen_if rdIf ();

  vga_line_fetch_addr_gen dut (
    .clk             (clk),
    .rst             (rst),
    .i_frame_start   (frameStart),
    .i_line_start    (lineStart),
    .i_line_idx      (lineIdx),
    .i_scroll_offset (scrollOffset),
    .i_swap_req      (swapReq),
    .rd_if           (rdIf.master),
    .o_busy          (busy),
    .o_front_buf     (frontBuf),
    .o_swap_done     (swapDone),
    .o_overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One-cycle pulse of the given inputs, sampled on the next rising edge
  task automatic applyStimulus(input logic frame, input logic line, input logic [9:0] idx,
                               input logic [9:0] scroll, input logic swap);
    @(posedge clk);
    #1;
    frameStart   = frame;
    lineStart    = line;
    lineIdx      = idx;
    scrollOffset = scroll;
    swapReq      = swap;
    @(posedge clk);
    #1;
    frameStart = 1'b0;
    lineStart  = 1'b0;
    swapReq    = 1'b0;
  endtask

  task automatic pushLine(input logic [1:0] bank, input logic [12:0] row);
    logic [8:0] col;
    for (int b = 0; b < 40; b++) begin
      col = 9'(b * 8);
      sbQ.push_back({bank, row, col});
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc = 0;
    rdIf.req_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      rdIf.req_ready = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  initial begin
    logic        stalled = 1'b0;
    logic [23:0] prevAddr = '0;
    logic [23:0] expAddr;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stallValidHeld", {31'd0, rdIf.req_valid}, 32'd1);
          checkOutput("stallAddrHeld", {8'd0, rdIf.req_addr}, {8'd0, prevAddr});
        end
        if (rdIf.req_valid && rdIf.req_ready) begin
          if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedReq: got %0h expected no request", rdIf.req_addr);
          end else begin
            expAddr = sbQ.pop_front();
            checkOutput("reqAddr", {8'd0, rdIf.req_addr}, {8'd0, expAddr});
          end
        end
        stalled  = rdIf.req_valid && !rdIf.req_ready;
        prevAddr = rdIf.req_addr;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValid", {31'd0, rdIf.req_valid}, 32'd0);
    checkOutput("rstAddr", {8'd0, rdIf.req_addr}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstFront", {31'd0, frontBuf}, 32'd0);
    checkOutput("rstSwapDone", {31'd0, swapDone}, 32'd0);
    checkOutput("rstOverrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;

    // Plain line, full-rate ready
    readyMode = 0;
    pushLine(2'd1, 13'd5);
    applyStimulus(1'b0, 1'b1, 10'd5, 10'd0, 1'b0);
    checkOutput("line5Busy", {31'd0, busy}, 32'd1);
    checkOutput("line5Valid", {31'd0, rdIf.req_valid}, 32'd1);
    waitIdle(100, "line5Done");
    checkOutput("line5Drained", sbQ.size(), 32'd0);
    checkOutput("line5NoOverrun", {31'd0, overrun}, 32'd0);

    // Scroll with framebuffer wrap
    applyStimulus(1'b1, 1'b0, 10'd0, 10'd10, 1'b0);
    pushLine(2'd1, 13'd3);
    applyStimulus(1'b0, 1'b1, 10'd505, 10'd0, 1'b0);
    waitIdle(100, "wrapDone");
    pushLine(2'd1, 13'd511);
    applyStimulus(1'b0, 1'b1, 10'd501, 10'd0, 1'b0);
    waitIdle(100, "row511Done");
    checkOutput("wrapDrained", sbQ.size(), 32'd0);

    // Stalled controller
    readyMode = 1;
    pushLine(2'd1, 13'd17);
    applyStimulus(1'b0, 1'b1, 10'd7, 10'd0, 1'b0);
    waitIdle(300, "stallDone");
    checkOutput("stallDrained", sbQ.size(), 32'd0);
    readyMode = 0;

    // Swap requested mid-frame, applied at frame_start
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
    checkOutput("swapPendFront", {31'd0, frontBuf}, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
    checkOutput("swapFront", {31'd0, frontBuf}, 32'd1);
    checkOutput("swapDonePulse", {31'd0, swapDone}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("swapDoneLow", {31'd0, swapDone}, 32'd0);
    pushLine(2'd2, 13'd20);
    applyStimulus(1'b0, 1'b1, 10'd20, 10'd0, 1'b0);
    waitIdle(100, "bankBDone");

    // Several swap requests collapse to a single toggle
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
    checkOutput("collapseFront", {31'd0, frontBuf}, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
    checkOutput("noSwapFront", {31'd0, frontBuf}, 32'd0);
    checkOutput("noSwapDone", {31'd0, swapDone}, 32'd0);

    // frame_start, swap_req and line_start together: new scroll and new buffer apply
    pushLine(2'd2, 13'd18);
    applyStimulus(1'b1, 1'b1, 10'd500, 10'd30, 1'b1);
    checkOutput("sameCycFront", {31'd0, frontBuf}, 32'd1);
    waitIdle(100, "sameCycDone");
    checkOutput("sameCycDrained", sbQ.size(), 32'd0);

    // line_start while busy is ignored and flagged
    readyMode = 1;
    pushLine(2'd2, 13'd30);
    applyStimulus(1'b0, 1'b1, 10'd0, 10'd0, 1'b0);
    repeat (4) @(posedge clk);
    applyStimulus(1'b0, 1'b1, 10'd100, 10'd0, 1'b0);
    checkOutput("overrunSet", {31'd0, overrun}, 32'd1);
    waitIdle(300, "overrunLineDone");
    checkOutput("overrunDrained", sbQ.size(), 32'd0);
    checkOutput("overrunSticky", {31'd0, overrun}, 32'd1);

    // Asynchronous reset in the middle of a burst train
    pushLine(2'd2, 13'd31);
    applyStimulus(1'b0, 1'b1, 10'd1, 10'd0, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstValid", {31'd0, rdIf.req_valid}, 32'd0);
    checkOutput("asyncRstBusy", {31'd0, busy}, 32'd0);
    sbQ.delete();
    @(posedge clk);
    #1;
    checkOutput("asyncRstFront", {31'd0, frontBuf}, 32'd0);
    checkOutput("asyncRstOverrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    readyMode = 0;

    pushLine(2'd1, 13'd2);
    applyStimulus(1'b0, 1'b1, 10'd2, 10'd0, 1'b0);
    waitIdle(100, "postRstDone");
    checkOutput("postRstDrained", sbQ.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
